// File: rtl/dm_arb_pkg.sv
// Shared definitions for the data-memory port arbiter: FSM state encoding,
// requester identifiers and the DMType codes that travel with each access.
package dm_arb_pkg;

  // Arbiter FSM state encoding
  localparam logic [1:0] ARB_IDLE  = 2'd0;
  localparam logic [1:0] ARB_DLOCK = 2'd1;
  localparam logic [1:0] ARB_REL   = 2'd2;

  // Requester identifiers
  typedef enum logic {
    PORT_C = 1'b0,
    PORT_D = 1'b1
  } port_e;

  // DMType access-size codes as understood by dm
  localparam logic [2:0] DM_WORD   = 3'd0;
  localparam logic [2:0] DM_HALF   = 3'd1;
  localparam logic [2:0] DM_HALF_U = 3'd2;
  localparam logic [2:0] DM_BYTE   = 3'd3;
  localparam logic [2:0] DM_BYTE_U = 3'd4;

endpackage

// File: rtl/arb_sat_counter.sv
// Saturating up-counter with synchronous clear. Counts inc pulses up to MAX
// and holds there; hit flags cnt == MAX. Clear takes priority over increment.
module arb_sat_counter #(
  parameter int WIDTH = 4,
  parameter int MAX   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic [WIDTH-1:0] cnt,
  output logic             hit
);

  localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX);

  // Count state: reset/clear to zero, otherwise step toward MAX and hold
  // NOTE: sequential state uses non-blocking (<=) so every flop samples
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (inc && (cnt != MAX_V)) begin
      cnt <= cnt + WIDTH'(1);
    end
  end

  assign hit = (cnt == MAX_V);

endmodule

// File: rtl/dm_port_arbiter.sv
// Data-memory port arbiter between the pipeline CPU MEM stage (C) and a
// debug/program-loader master (D). The CPU has fixed priority; the debug
// master can lock the port for a bounded burst, after which one release
// cycle is reserved for the CPU. Read data returns one cycle after grant.
// Optional build macro: DM_ARB_FAIRNESS_EN lets a debug request that has
// been denied STARVE_MAX consecutive cycles win over the CPU once.
module dm_port_arbiter
  import dm_arb_pkg::*;
#(
  parameter int AW         = 32,
  parameter int DW         = 32,
  parameter int LOCK_MAX   = 16,
  parameter int STARVE_MAX = 8
) (
  input  logic          clk,
  input  logic          rst,
  // CPU port
  input  logic          c_req,
  input  logic          c_we,
  input  logic [2:0]    c_type,
  input  logic [AW-1:0] c_addr,
  input  logic [DW-1:0] c_wdata,
  output logic          c_gnt,
  output logic          c_stall,
  output logic          c_rvalid,
  output logic [DW-1:0] c_rdata,
  // Debug port
  input  logic          d_req,
  input  logic          d_we,
  input  logic [2:0]    d_type,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  input  logic          d_lock,
  output logic          d_gnt,
  output logic          d_rvalid,
  output logic [DW-1:0] d_rdata,
  // Memory side
  output logic          m_we,
  output logic [2:0]    m_type,
  output logic [AW-1:0] m_addr,
  output logic [DW-1:0] m_wdata,
  input  logic [DW-1:0] m_rdata
);

  localparam int LCW = $clog2(LOCK_MAX + 1);

  logic [1:0]     state;
  logic [1:0]     next_state;
  logic           win_valid;
  port_e          win_port;
  logic [LCW-1:0] lock_cnt;
  logic           lock_hit;
  logic           last_lock_access;
  logic           starve_hit;

  // Per-cycle winner selection; reset blocks every grant
  // NOTE: every always_comb output gets a default before any branch, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    win_valid = 1'b0;
    win_port  = PORT_C;
    if (!rst) begin
      case (state)
        ARB_IDLE: begin
          if (starve_hit && d_req) begin
            win_valid = 1'b1;
            win_port  = PORT_D;
          end else if (c_req) begin
            win_valid = 1'b1;
            win_port  = PORT_C;
          end else if (d_req) begin
            win_valid = 1'b1;
            win_port  = PORT_D;
          end
        end
        ARB_DLOCK: begin
          // lock_hit cannot be reached (the burst ends on the LOCK_MAX-th
          // grant) but it keeps the burst bounded if that ever changes.
          if (d_req && !lock_hit) begin
            win_valid = 1'b1;
            win_port  = PORT_D;
          end
        end
        ARB_REL: begin
          if (c_req) begin
            win_valid = 1'b1;
            win_port  = PORT_C;
          end
        end
        default: ;
      endcase
    end
  end

  assign c_gnt   = win_valid && (win_port == PORT_C);
  assign d_gnt   = win_valid && (win_port == PORT_D);
  assign c_stall = c_req && !c_gnt;

  // Memory-side mux: winner's fields, all zero when nobody is granted
  always_comb begin
    m_we    = 1'b0;
    m_type  = '0;
    m_addr  = '0;
    m_wdata = '0;
    if (c_gnt) begin
      m_we    = c_we;
      m_type  = c_type;
      m_addr  = c_addr;
      m_wdata = c_wdata;
    end else if (d_gnt) begin
      m_we    = d_we;
      m_type  = d_type;
      m_addr  = d_addr;
      m_wdata = d_wdata;
    end
  end

  // lock_cnt holds the number of burst accesses already performed, so the
  // grant made while it equals LOCK_MAX-1 is the LOCK_MAX-th and last one.
  assign last_lock_access = d_gnt && (lock_cnt == LCW'(LOCK_MAX - 1));

  // Next-state logic for ownership of the port
  always_comb begin
    next_state = state;
    case (state)
      ARB_IDLE: begin
        if (d_gnt && d_lock) begin
          // A one-access burst is already exhausted by the opening grant
          next_state = (LOCK_MAX == 1) ? ARB_REL : ARB_DLOCK;
        end
      end
      ARB_DLOCK: begin
        if (!d_lock || last_lock_access) begin
          next_state = ARB_REL;
        end
      end
      ARB_REL:  next_state = ARB_IDLE;
      default:  next_state = ARB_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ARB_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Burst length counter: counts debug grants while the lock is held and
  // clears whenever the next state is not ARB_DLOCK
  arb_sat_counter #(
    .WIDTH (LCW),
    .MAX   (LOCK_MAX)
  ) u_lock_cnt (
    .clk (clk),
    .rst (rst),
    .inc (d_gnt),
    .clr (next_state != ARB_DLOCK),
    .cnt (lock_cnt),
    .hit (lock_hit)
  );

`ifdef DM_ARB_FAIRNESS_EN
  localparam int SCW = $clog2(STARVE_MAX + 1);

  logic [SCW-1:0] starve_cnt;

  // Consecutive denied-request counter for the debug master
  arb_sat_counter #(
    .WIDTH (SCW),
    .MAX   (STARVE_MAX)
  ) u_starve_cnt (
    .clk (clk),
    .rst (rst),
    .inc (d_req && !d_gnt),
    .clr (d_gnt || !d_req),
    .cnt (starve_cnt),
    .hit (starve_hit)
  );
`else
  // Strict CPU priority: the debug master may wait indefinitely
  assign starve_hit = 1'b0;
`endif

  // Read return: capture dm output for the port that won a read this cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      c_rvalid <= 1'b0;
      d_rvalid <= 1'b0;
      c_rdata  <= '0;
      d_rdata  <= '0;
    end else begin
      c_rvalid <= c_gnt && !c_we;
      d_rvalid <= d_gnt && !d_we;
      if (c_gnt && !c_we) begin
        c_rdata <= m_rdata;
      end
      if (d_gnt && !d_we) begin
        d_rdata <= m_rdata;
      end
    end
  end

endmodule

// File: tb/tb_dm_port_arbiter.sv
// Directed testbench for dm_port_arbiter with a small byte-addressed data
// memory model. Inputs change on the falling edge; outputs are sampled 1 ns
// later, well away from the rising edge.
module tb_dm_port_arbiter;
  import dm_arb_pkg::*;

  localparam int AW         = 32;
  localparam int DW         = 32;
  localparam int LOCK_MAX   = 4;
  localparam int STARVE_MAX = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          c_req, c_we;
  logic [2:0]    c_type;
  logic [AW-1:0] c_addr;
  logic [DW-1:0] c_wdata;
  logic          c_gnt, c_stall, c_rvalid;
  logic [DW-1:0] c_rdata;
  logic          d_req, d_we, d_lock;
  logic [2:0]    d_type;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic          d_gnt, d_rvalid;
  logic [DW-1:0] d_rdata;
  logic          m_we;
  logic [2:0]    m_type;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata;
  logic [DW-1:0] m_rdata;

  logic [31:0] mem [0:63];

  int checks = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  dm_port_arbiter #(
    .AW (AW), .DW (DW), .LOCK_MAX (LOCK_MAX), .STARVE_MAX (STARVE_MAX)
  ) dut (
    .clk (clk), .rst (rst),
    .c_req (c_req), .c_we (c_we), .c_type (c_type), .c_addr (c_addr), .c_wdata (c_wdata),
    .c_gnt (c_gnt), .c_stall (c_stall), .c_rvalid (c_rvalid), .c_rdata (c_rdata),
    .d_req (d_req), .d_we (d_we), .d_type (d_type), .d_addr (d_addr), .d_wdata (d_wdata),
    .d_lock (d_lock), .d_gnt (d_gnt), .d_rvalid (d_rvalid), .d_rdata (d_rdata),
    .m_we (m_we), .m_type (m_type), .m_addr (m_addr), .m_wdata (m_wdata), .m_rdata (m_rdata)
  );

  // Memory model read path: little-endian, size/sign per DMType
  function automatic logic [31:0] dm_read(input logic [31:0] a, input logic [2:0] t);
    logic [31:0] w;
    logic [15:0] h;
    logic [7:0]  b;
    w = mem[a[7:2]];
    h = a[1] ? w[31:16] : w[15:0];
    b = 8'(w >> {a[1:0], 3'b000});
    case (t)
      DM_HALF:   return {{16{h[15]}}, h};
      DM_HALF_U: return {16'h0000, h};
      DM_BYTE:   return {{24{b[7]}}, b};
      DM_BYTE_U: return {24'h000000, b};
      default:   return w;
    endcase
  endfunction

  assign m_rdata = dm_read(m_addr, m_type);

  // Memory model write path
  always @(posedge clk) begin
    if (m_we) begin
      case (m_type)
        DM_HALF, DM_HALF_U: begin
          if (m_addr[1]) mem[m_addr[7:2]][31:16] <= m_wdata[15:0];
          else           mem[m_addr[7:2]][15:0]  <= m_wdata[15:0];
        end
        DM_BYTE, DM_BYTE_U: mem[m_addr[7:2]][8*m_addr[1:0] +: 8] <= m_wdata[7:0];
        default: mem[m_addr[7:2]] <= m_wdata;
      endcase
    end
  end

  task automatic idle_inputs();
    c_req = 1'b0; c_we = 1'b0; c_type = DM_WORD; c_addr = '0; c_wdata = '0;
    d_req = 1'b0; d_we = 1'b0; d_type = DM_WORD; d_addr = '0; d_wdata = '0;
    d_lock = 1'b0;
  endtask

  // 1: both requesting during reset -> nothing granted, CPU stalled
  task automatic test_reset();
    rst = 1'b1;
    idle_inputs();
    c_req = 1'b1; d_req = 1'b1; d_lock = 1'b1; d_we = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk); #1;
      checks++; if (c_gnt !== 1'b0)  begin fails++; $display("FAIL reset_c_gnt: got %b want 0", c_gnt); end
      checks++; if (d_gnt !== 1'b0)  begin fails++; $display("FAIL reset_d_gnt: got %b want 0", d_gnt); end
      checks++; if (m_we !== 1'b0)   begin fails++; $display("FAIL reset_m_we: got %b want 0", m_we); end
      checks++; if (c_stall !== 1'b1) begin fails++; $display("FAIL reset_c_stall: got %b want 1", c_stall); end
      checks++; if ({c_rvalid, d_rvalid} !== 2'b00) begin fails++; $display("FAIL reset_rvalid: got %b want 00", {c_rvalid, d_rvalid}); end
      checks++; if ({c_rdata, d_rdata} !== 64'h0) begin fails++; $display("FAIL reset_rdata: got %h want 0", {c_rdata, d_rdata}); end
    end
    @(negedge clk);
    rst = 1'b0;
    idle_inputs();
  endtask

  // 2: simultaneous CPU read and debug write -> CPU first, debug next cycle
  task automatic test_collision();
    @(negedge clk);
    c_req = 1'b1; c_we = 1'b0; c_type = DM_WORD; c_addr = 32'h10;
    d_req = 1'b1; d_we = 1'b1; d_type = DM_WORD; d_addr = 32'h20; d_wdata = 32'hDEADBEEF;
    #1;
    checks++; if (c_gnt !== 1'b1)  begin fails++; $display("FAIL coll_c_gnt: got %b want 1", c_gnt); end
    checks++; if (d_gnt !== 1'b0)  begin fails++; $display("FAIL coll_d_gnt: got %b want 0", d_gnt); end
    checks++; if (c_stall !== 1'b0) begin fails++; $display("FAIL coll_c_stall: got %b want 0", c_stall); end
    checks++; if (m_addr !== 32'h10) begin fails++; $display("FAIL coll_m_addr_c: got %h want 00000010", m_addr); end
    checks++; if (m_we !== 1'b0)   begin fails++; $display("FAIL coll_m_we_c: got %b want 0", m_we); end
    @(negedge clk);
    c_req = 1'b0;
    #1;
    checks++; if (c_rvalid !== 1'b1) begin fails++; $display("FAIL coll_c_rvalid: got %b want 1", c_rvalid); end
    checks++; if (c_rdata !== 32'hCAFE0010) begin fails++; $display("FAIL coll_c_rdata: got %h want cafe0010", c_rdata); end
    checks++; if (d_gnt !== 1'b1)  begin fails++; $display("FAIL coll_d_gnt2: got %b want 1", d_gnt); end
    checks++; if (m_we !== 1'b1)   begin fails++; $display("FAIL coll_m_we_d: got %b want 1", m_we); end
    checks++; if (m_addr !== 32'h20) begin fails++; $display("FAIL coll_m_addr_d: got %h want 00000020", m_addr); end
    checks++; if (m_wdata !== 32'hDEADBEEF) begin fails++; $display("FAIL coll_m_wdata: got %h want deadbeef", m_wdata); end
    @(negedge clk);
    idle_inputs();
    #1;
    checks++; if (mem[8] !== 32'hDEADBEEF) begin fails++; $display("FAIL coll_mem: got %h want deadbeef", mem[8]); end
    checks++; if ({c_rvalid, d_rvalid} !== 2'b00) begin fails++; $display("FAIL coll_rvalid_after: got %b want 00", {c_rvalid, d_rvalid}); end
  endtask

  // 3: locked burst of 6 writes with LOCK_MAX=4; CPU read arrives on write 2
  task automatic test_locked_burst();
    logic [6:0] exp_d = 7'b1101111;
    logic [6:0] exp_c = 7'b0010000;
    logic [6:0] creq  = 7'b0011110;
    int k = 0;
    int stalls = 0;
    for (int cyc = 0; cyc < 7; cyc++) begin
      @(negedge clk);
      d_req = 1'b1; d_we = 1'b1; d_lock = 1'b1; d_type = DM_WORD;
      d_addr = 32'h80 + 32'(4 * k); d_wdata = 32'hA0000000 + 32'(k);
      c_req = creq[cyc]; c_we = 1'b0; c_type = DM_WORD; c_addr = 32'h10;
      #1;
      checks++; if (d_gnt !== exp_d[cyc]) begin fails++; $display("FAIL lock_d_gnt cyc%0d: got %b want %b", cyc, d_gnt, exp_d[cyc]); end
      checks++; if (c_gnt !== exp_c[cyc]) begin fails++; $display("FAIL lock_c_gnt cyc%0d: got %b want %b", cyc, c_gnt, exp_c[cyc]); end
      checks++; if (c_stall !== (creq[cyc] & ~exp_c[cyc])) begin fails++; $display("FAIL lock_c_stall cyc%0d: got %b want %b", cyc, c_stall, creq[cyc] & ~exp_c[cyc]); end
      checks++; if (c_rvalid !== (cyc == 5)) begin fails++; $display("FAIL lock_c_rvalid cyc%0d: got %b want %b", cyc, c_rvalid, cyc == 5); end
      if (c_stall === 1'b1) stalls++;
      if (exp_d[cyc]) k++;
    end
    checks++; if (stalls != 3) begin fails++; $display("FAIL lock_stall_count: got %0d want 3", stalls); end
    // Drop the lock: DLOCK -> REL -> IDLE
    @(negedge clk); idle_inputs();
    @(negedge clk);
    @(negedge clk); #1;
    checks++; if (dut.state !== ARB_IDLE) begin fails++; $display("FAIL lock_state_end: got %0d want %0d", dut.state, ARB_IDLE); end
    checks++; if (mem[37] !== 32'hA0000005) begin fails++; $display("FAIL lock_mem_last: got %h want a0000005", mem[37]); end
  endtask

  // 4: CPU and debug both requesting continuously
  task automatic test_starvation();
    @(negedge clk);
    c_req = 1'b1; c_we = 1'b0; c_type = DM_WORD; c_addr = 32'h10;
    d_req = 1'b1; d_we = 1'b0; d_type = DM_WORD; d_addr = 32'h20; d_lock = 1'b0;
`ifdef DM_ARB_FAIRNESS_EN
    for (int cyc = 1; cyc <= 10; cyc++) begin
      if (cyc > 1) @(negedge clk);
      #1;
      checks++; if (d_gnt !== (cyc == 9)) begin fails++; $display("FAIL starve_d_gnt cyc%0d: got %b want %b", cyc, d_gnt, cyc == 9); end
      checks++; if (c_gnt !== (cyc != 9)) begin fails++; $display("FAIL starve_c_gnt cyc%0d: got %b want %b", cyc, c_gnt, cyc != 9); end
      if (cyc == 10) begin
        checks++; if (dut.starve_cnt !== '0) begin fails++; $display("FAIL starve_cnt_clear: got %0d want 0", dut.starve_cnt); end
        checks++; if (d_rvalid !== 1'b1) begin fails++; $display("FAIL starve_d_rvalid: got %b want 1", d_rvalid); end
        checks++; if (d_rdata !== 32'hDEADBEEF) begin fails++; $display("FAIL starve_d_rdata: got %h want deadbeef", d_rdata); end
      end
    end
`else
    for (int cyc = 1; cyc <= 20; cyc++) begin
      if (cyc > 1) @(negedge clk);
      #1;
      checks++; if (d_gnt !== 1'b0) begin fails++; $display("FAIL strict_d_gnt cyc%0d: got %b want 0", cyc, d_gnt); end
      checks++; if (c_gnt !== 1'b1) begin fails++; $display("FAIL strict_c_gnt cyc%0d: got %b want 1", cyc, c_gnt); end
    end
`endif
    @(negedge clk);
    idle_inputs();
  endtask

  // 5: debug word write then CPU sub-word reads of the same and a nearby word
  task automatic test_read_after_write();
    @(negedge clk);
    d_req = 1'b1; d_we = 1'b1; d_type = DM_WORD; d_addr = 32'h40; d_wdata = 32'h12345678;
    #1;
    checks++; if (d_gnt !== 1'b1) begin fails++; $display("FAIL raw_d_gnt: got %b want 1", d_gnt); end
    @(negedge clk);
    idle_inputs();
    c_req = 1'b1; c_we = 1'b0; c_type = DM_BYTE_U; c_addr = 32'h41;
    #1;
    checks++; if (c_gnt !== 1'b1) begin fails++; $display("FAIL raw_c_gnt: got %b want 1", c_gnt); end
    @(negedge clk);
    c_type = DM_HALF; c_addr = 32'h42;
    #1;
    checks++; if (c_rdata !== 32'h00000056) begin fails++; $display("FAIL raw_lbu: got %h want 00000056", c_rdata); end
    @(negedge clk);
    c_type = DM_BYTE; c_addr = 32'h44;
    #1;
    checks++; if (c_rdata !== 32'h00001234) begin fails++; $display("FAIL raw_lh: got %h want 00001234", c_rdata); end
    @(negedge clk);
    idle_inputs();
    #1;
    checks++; if (c_rdata !== 32'hFFFFFFF0) begin fails++; $display("FAIL raw_lb_sext: got %h want fffffff0", c_rdata); end
  endtask

  // 6: reset while debug holds the lock and keeps requesting reads
  task automatic test_reset_mid_lock();
    @(negedge clk);
    d_req = 1'b1; d_we = 1'b0; d_lock = 1'b1; d_type = DM_WORD; d_addr = 32'h40;
    #1;
    checks++; if (d_gnt !== 1'b1) begin fails++; $display("FAIL rml_d_gnt_lock: got %b want 1", d_gnt); end
    @(negedge clk);
    rst = 1'b1;
    c_req = 1'b1; c_we = 1'b0; c_type = DM_WORD; c_addr = 32'h10;
    #1;
    checks++; if (dut.state !== ARB_DLOCK) begin fails++; $display("FAIL rml_state_locked: got %0d want %0d", dut.state, ARB_DLOCK); end
    checks++; if ({c_gnt, d_gnt} !== 2'b00) begin fails++; $display("FAIL rml_gnt_in_rst: got %b want 00", {c_gnt, d_gnt}); end
    checks++; if (c_stall !== 1'b1) begin fails++; $display("FAIL rml_c_stall: got %b want 1", c_stall); end
    checks++; if (d_rvalid !== 1'b1) begin fails++; $display("FAIL rml_d_rvalid_prev: got %b want 1", d_rvalid); end
    checks++; if (d_rdata !== 32'h12345678) begin fails++; $display("FAIL rml_d_rdata_prev: got %h want 12345678", d_rdata); end
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++; if (d_rvalid !== 1'b0) begin fails++; $display("FAIL rml_d_rvalid: got %b want 0", d_rvalid); end
    checks++; if (dut.state !== ARB_IDLE) begin fails++; $display("FAIL rml_state: got %0d want %0d", dut.state, ARB_IDLE); end
    checks++; if (c_gnt !== 1'b1) begin fails++; $display("FAIL rml_c_gnt: got %b want 1", c_gnt); end
    checks++; if (d_gnt !== 1'b0) begin fails++; $display("FAIL rml_d_gnt: got %b want 0", d_gnt); end
    @(negedge clk);
    idle_inputs();
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 32'h0;
    mem[4]  = 32'hCAFE0010;
    mem[17] = 32'h000000F0;
    rst = 1'b1;
    idle_inputs();
    test_reset();
    test_collision();
    test_locked_burst();
    test_starvation();
    test_read_after_write();
    test_reset_mid_lock();
    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
